// File: rtl/vmu_pkg.sv
// Shared types and lane geometry for the vector load/store engine.
package vmu_pkg;

  localparam int VMU_LANES  = 16;
  localparam int VMU_LANE_W = 16;
  localparam int VMU_CNT_W  = $clog2(VMU_LANES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } vmu_state_t;

  // Extract lane idx from a flat vector (lane i = bits [W*i+W-1:W*i]).
  function automatic logic [VMU_LANE_W-1:0] lane_slice(
    input logic [VMU_LANES*VMU_LANE_W-1:0] vec,
    input logic [VMU_CNT_W-1:0]            idx
  );
    return vec[idx*VMU_LANE_W +: VMU_LANE_W];
  endfunction

endpackage

// File: rtl/vmu_addr_gen.sv
// Lane counter and address accumulator: loads the base, adds the stride on each ack.
module vmu_addr_gen #(
  parameter int LANES  = 16,
  parameter int ADDR_W = 16,
  localparam int CNT_W = $clog2(LANES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              adv,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] stride,
  output logic [CNT_W-1:0]  cnt,
  output logic [ADDR_W-1:0] lane_addr,
  output logic              last
);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] acc_q, acc_d;
  logic [ADDR_W-1:0] stride_q, stride_d;

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    stride_d = stride_q;
    if (load) begin
      cnt_d    = '0;
      acc_d    = base;
      stride_d = stride;
    end else if (adv) begin
      // Address wraps naturally at 2^ADDR_W; counter wraps to 0 after the last lane.
      cnt_d = cnt_q + CNT_W'(1);
      acc_d = acc_q + stride_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      stride_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      stride_q <= stride_d;
    end
  end

  assign cnt       = cnt_q;
  assign lane_addr = acc_q;
  assign last      = (cnt_q == CNT_W'(LANES-1));

endmodule

// File: rtl/vec_mem_unit.sv
// Vector load/store engine: moves one vector between the datapath and a lane-wide memory,
// one lane per transaction. Define VMU_STRIDE_EN to add a strided-address `stride` port.
module vec_mem_unit
  import vmu_pkg::*;
#(
  parameter int LANES  = VMU_LANES,
  parameter int LANE_W = VMU_LANE_W,
  parameter int ADDR_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    is_store,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [LANES*LANE_W-1:0] st_data,
`ifdef VMU_STRIDE_EN
  input  logic [ADDR_W-1:0]       stride,
`endif
  output logic                    busy,
  output logic                    done,
  output logic [LANES*LANE_W-1:0] ld_data,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [LANE_W-1:0]       mem_wdata,
  output logic                    mem_re,
  output logic                    mem_we,
  input  logic [LANE_W-1:0]       mem_rdata,
  input  logic                    mem_ack
);

  localparam int CNT_W = $clog2(LANES);

  vmu_state_t                   state_q, state_d;
  logic                         is_store_q, is_store_d;
  logic [LANES*LANE_W-1:0]      st_q, st_d;
  logic [LANES-1:0][LANE_W-1:0] ld_q, ld_d;

  logic              ag_load, ag_adv, ag_last;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] lane_addr;
  logic [ADDR_W-1:0] stride_w;

`ifdef VMU_STRIDE_EN
  assign stride_w = stride;
`else
  assign stride_w = ADDR_W'(1);
`endif

  vmu_addr_gen #(.LANES(LANES), .ADDR_W(ADDR_W)) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ag_load),
    .adv       (ag_adv),
    .base      (addr),
    .stride    (stride_w),
    .cnt       (cnt),
    .lane_addr (lane_addr),
    .last      (ag_last)
  );

  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    st_d       = st_q;
    ld_d       = ld_q;
    ag_load    = 1'b0;
    ag_adv     = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        state_d    = XFER;
        is_store_d = is_store;
        st_d       = st_data;
        ag_load    = 1'b1;
      end
      XFER: if (mem_ack) begin
        ag_adv = 1'b1;
        if (!is_store_q) ld_d[cnt] = mem_rdata;
        if (ag_last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      is_store_q <= 1'b0;
      st_q       <= '0;
      ld_q       <= '0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      st_q       <= st_d;
      ld_q       <= ld_d;
    end
  end

  // Every output decodes registered state only, so inputs never reach outputs combinationally.
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign mem_re    = (state_q == XFER) && !is_store_q;
  assign mem_we    = (state_q == XFER) &&  is_store_q;
  assign mem_addr  = lane_addr;
  assign mem_wdata = lane_slice(st_q, cnt);
  assign ld_data   = ld_q;

endmodule

// File: tb/tb_vec_mem_unit.sv
// Scoreboarded random bench for vec_mem_unit with a word-level reference memory model.
module tb_vec_mem_unit;

  logic         clk = 1'b0;
  logic         rst_n, start, is_store, mem_ack;
  logic [15:0]  addr, stride, mem_rdata, mem_addr, mem_wdata;
  logic [255:0] st_data, ld_data;
  logic         busy, done, mem_re, mem_we;

  always #5 clk = ~clk;

  vec_mem_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_store  (is_store),
    .addr      (addr),
    .st_data   (st_data),
`ifdef VMU_STRIDE_EN
    .stride    (stride),
`endif
    .busy      (busy),
    .done      (done),
    .ld_data   (ld_data),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  logic [15:0]  mem     [0:65535];  // physical memory seen by the DUT
  logic [15:0]  ref_mem [0:65535];  // architectural memory per the model
  logic [255:0] exp_q[$];
  logic [15:0]  rd_q[$];
  logic [31:0]  wr_q[$];
  logic [255:0] last_ld = '0;

  int checks = 0, errors = 0;
  int ack_mode = 0, ack_cnt = 0, wait_total = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: lane i moves between the vector and word (a + i*s) mod 2^16.
  task automatic issue(input bit st, input logic [15:0] a, input logic [15:0] s,
                       input logic [255:0] d, input int mode);
    logic [255:0] ld;
    logic [15:0]  la;
    int n = 0;
`ifndef VMU_STRIDE_EN
    s = 16'd1;
`endif
    while (busy && n < 200) begin @(posedge clk); #1; n++; end
    chk("idle_before_start", busy, 0);
    ld = last_ld;
    for (int i = 0; i < 16; i++) begin
      la = a + 16'(i) * s;
      if (st) begin
        wr_q.push_back({la, d[i*16 +: 16]});
        ref_mem[la] = d[i*16 +: 16];
      end else begin
        rd_q.push_back(la);
        ld[i*16 +: 16] = ref_mem[la];
      end
    end
    exp_q.push_back(ld);
    last_ld  = ld;
    ack_mode = mode;
    ack_cnt  = 0;
    start = 1'b1; is_store = st; addr = a; stride = s; st_data = d;
    @(posedge clk); #1;
    start = 1'b0; addr = 16'($urandom); stride = 16'($urandom);
    st_data = {8{$urandom}};
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 2000) begin @(posedge clk); #1; n++; end
    chk("done_within_budget", done, 1);
    @(posedge clk); #1;
  endtask

  task automatic run_op(input bit st, input logic [15:0] a, input logic [15:0] s,
                        input logic [255:0] d, input int mode);
    issue(st, a, s, d, mode);
    wait_done();
  endtask

  // Memory responder: decides ack per cycle, checks request hold and addresses.
  bit          req, a, pend = 0;
  int          lane_wait = 0;
  logic [15:0] p_addr, p_wdata;
  logic        p_we;
  initial begin
    mem_ack = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      req = mem_re | mem_we;
      case (ack_mode)
        0:       a = 1'b1;
        1:       a = req && (lane_wait == 2);
        default: a = ($urandom_range(0, 2) == 0);
      endcase
      mem_rdata = 16'($urandom);
      if (req) begin
        chk("re_we_exclusive", mem_re & mem_we, 0);
        if (pend) begin
          chk("hold_addr", mem_addr, p_addr);
          chk("hold_we", mem_we, p_we);
          if (mem_we) chk("hold_wdata", mem_wdata, p_wdata);
        end
        if (a) begin
          ack_cnt++; lane_wait = 0; pend = 0;
          if (mem_re) begin
            mem_rdata = mem[mem_addr];
            chk("read_expected", rd_q.size() != 0, 1);
            if (rd_q.size() != 0) chk("read_addr", mem_addr, rd_q.pop_front());
          end else begin
            chk("write_expected", wr_q.size() != 0, 1);
            if (wr_q.size() != 0) chk("write_addr_data", {mem_addr, mem_wdata}, wr_q.pop_front());
            mem[mem_addr] = mem_wdata;
          end
        end else begin
          wait_total++; lane_wait++; pend = 1;
          p_addr = mem_addr; p_wdata = mem_wdata; p_we = mem_we;
        end
      end else begin
        pend = 0; lane_wait = 0;
      end
      mem_ack = a;
    end
  end

  // Monitor: on done, compare the vector, latency and lane completion against the scoreboard.
  int bcnt = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) bcnt = 0;
      else begin
        if (busy) bcnt++;
        if (done) begin
          chk("done_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) chk("ld_data", ld_data, exp_q.pop_front());
          chk("busy_cycles", bcnt, 17 + wait_total);
          chk("all_lanes_moved", rd_q.size() + wr_q.size(), 0);
          wait_total = 0; bcnt = 0;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0]  v;
    logic [255:0] d;
    int n;
    rst_n = 1'b0; start = 1'b0; is_store = 1'b0; addr = '0; stride = 16'd1; st_data = '0;
    for (int i = 0; i < 65536; i++) begin
      v = 16'($urandom); mem[i] = v; ref_mem[i] = v;
    end
    for (int i = 0; i < 16; i++) begin
      mem[16'h0100 + i] = 16'h1000 + 16'(i); ref_mem[16'h0100 + i] = 16'h1000 + 16'(i);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);      chk("rst_done", done, 0);
    chk("rst_mem_re", mem_re, 0);  chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0); chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_ld_data", ld_data, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero-wait load, store with two waits per lane, readback, wrap-around.
    run_op(0, 16'h0100, 16'd1, '0, 0);
    for (int i = 0; i < 16; i++) d[i*16 +: 16] = 16'hA0A0 ^ 16'(i);
    run_op(1, 16'h0020, 16'd1, d, 1);
    run_op(0, 16'h0020, 16'd1, '0, 2);
    run_op(0, 16'hFFF8, 16'd1, '0, 0);
`ifdef VMU_STRIDE_EN
    run_op(0, 16'h0010, 16'd4, '0, 0);
    run_op(0, 16'h0010, 16'd0, '0, 2);
    run_op(1, 16'h0010, 16'd0, {8{$urandom}}, 1);
`endif

    // Start pulses during XFER and DONE must be ignored.
    issue(0, 16'h0200, 16'd1, '0, 0);
    repeat (4) begin @(posedge clk); #1; end
    start = 1'b1; addr = 16'h7777; is_store = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin @(posedge clk); #1; n++; end
    chk("done_after_busy_start", done, 1);
    start = 1'b1; addr = 16'h5555; is_store = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_in_done_ignored", busy, 0);

    // Reset after lane 6 acks aborts the load and clears outputs.
    issue(0, 16'h0300, 16'd1, '0, 0);
    n = 0;
    while (ack_cnt < 7 && n < 100) begin @(negedge clk); n++; end
    chk("lane6_ack_seen", ack_cnt >= 7, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    exp_q.delete(); rd_q.delete(); wr_q.delete();
    wait_total = 0; last_ld = '0;
    #1;
    chk("abort_busy", busy, 0);     chk("abort_done", done, 0);
    chk("abort_mem_re", mem_re, 0); chk("abort_mem_we", mem_we, 0);
    chk("abort_ld_data", ld_data, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(0, 16'h0300, 16'd1, '0, 0);

    // Random mix of loads and stores with random memory wait patterns.
    for (int k = 0; k < 24; k++) begin
      v = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 5));
      run_op(bit'($urandom_range(0, 1)), 16'($urandom), v, {8{$urandom}},
             int'($urandom_range(0, 2)));
    end

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vec_mem_unit.md
# vec_mem_unit

Multi-cycle vector load/store engine directly downstream of the ALU. For VLD/VST, the ALU produces a 16-bit effective address (base + offset). This block consumes that address and moves one 256-bit vector (16 lanes × 16 bits) between the vector datapath and a 16-bit-wide data memory, one lane per memory transaction. It stalls the pipeline via `busy` and signals completion with a one-cycle `done` pulse.

## Interface
- `LANES`, default 16: lanes per vector.
- `LANE_W`, default 16: bits per lane and per memory word.
- `ADDR_W`, default 16: memory address width.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin an operation; sampled only in IDLE.
- `is_store`  in  1  1 = VST, 0 = VLD; sampled with `start`.
- `addr`  in  ADDR_W  base address (ALU result[15:0]); sampled with `start`.
- `st_data`  in  LANES*LANE_W  vector to store; sampled with `start`.
- `busy`  out  1  high from the cycle after an accepted `start` through the DONE cycle.
- `done`  out  1  one-cycle completion pulse.
- `ld_data`  out  LANES*LANE_W  loaded vector; lane i = bits [16i+15:16i].
- `mem_addr`  out  ADDR_W  memory word address.
- `mem_wdata`  out  LANE_W  write data.
- `mem_re` / `mem_we`  out  1  read / write request; never both high.
- `mem_rdata`  in  LANE_W  read data; valid in the cycle `mem_ack` is high.
- `mem_ack`  in  1  memory completes the current request this cycle.

## Operation
- States: IDLE, XFER, DONE.
- **IDLE:** `start` = 1 captures `is_store`, `addr`, and `st_data`. The lane counter is set to 0 and the next state is XFER.
- **XFER:** drive a request for lane `cnt`.
  - `mem_addr` = `addr` + `cnt` (mod 2^ADDR_W; wraps 0xFFFF → 0x0000).
  - Store: `mem_we` = 1, `mem_wdata` = captured lane `cnt`.
  - Load: `mem_re` = 1. On `mem_ack`, write `mem_rdata` into `ld_data` lane `cnt`.
- **Request hold:** the request, address, and data stay stable until `mem_ack`. On `mem_ack`, `cnt` increments.
- **Leaving XFER:** `mem_ack` with `cnt` = LANES−1 moves to DONE. No request is issued in the following cycle.
- **DONE:** `done` = 1 for exactly one cycle, then IDLE.
- **`ld_data` validity:** valid from the DONE cycle onward, held until the next load writes lane 0. A store never modifies `ld_data`.
- **`start` while busy:** ignored, with no queuing. `start` during DONE is also ignored; the earliest re-accept is the following IDLE cycle.
- **`mem_ack` outside XFER:** ignored.
- **Reset:** `rst_n` low at any time, including mid-transfer, forces IDLE. Reset values:
  - `cnt` = 0.
  - `busy`, `done`, `mem_re`, `mem_we` = 0.
  - `mem_addr`, `mem_wdata` = 0.
  - `ld_data` = 0.
  - An aborted store leaves memory partially written; this is acceptable.

## Timing
- Accepted `start` at edge T: XFER with `busy` = 1 and the first request are visible after T.
- With zero-wait memory (`mem_ack` tied high), one lane completes per cycle: 16 XFER cycles, then DONE at cycle 17 after `start`, back in IDLE at cycle 18.
- Each wait cycle (request with `mem_ack` = 0) adds exactly one cycle.
- All outputs are registered or decoded from registered state only; no combinational path from any input to any output.

## Configuration
- `VMU_STRIDE_EN` defined:
  - Adds input port `stride` [ADDR_W−1:0], sampled with `start`.
  - Lane address = `addr` + `cnt` × `stride`, truncated to ADDR_W. It is computed incrementally by adding `stride` on each ack; no multiplier.
  - `stride` = 0 is legal: all lanes hit the same word.
- `VMU_STRIDE_EN` undefined: no `stride` port; the stride is fixed at 1.

## Structure
- Package `vmu_pkg` holds:
  - the state enum `vmu_state_t` (IDLE, XFER, DONE);
  - the constants `VMU_LANES` and `VMU_LANE_W`;
  - the lane-slice helper function.
- One sub-module, `vmu_addr_gen`: holds the lane counter and address accumulator (load base, advance on ack, last-lane flag).

## Test plan
- **Zero-wait load:** `addr` = 0x0100, memory[0x0100+i] = 0x1000+i, `mem_ack` = 1 → `done` at cycle 17; `ld_data` lane i = 0x1000+i; `busy` high for 17 cycles.
- **Store with waits:** `addr` = 0x0020, `st_data` lane i = 0xA0A0^i, ack every third cycle → exactly 16 writes to 0x0020..0x002F with correct data, each held stable until ack; `done` after 48 XFER cycles.
- **Wrap-around:** load at `addr` = 0xFFF8 → lanes 0–7 from 0xFFF8–0xFFFF, lanes 8–15 from 0x0000–0x0007.
- **Start while busy:** pulse `start` with different `addr` at XFER cycle 5 and during DONE → ignored; the original transfer completes unchanged and `ld_data` is intact.
- **Mid-transfer reset:** deassert `rst_n` after lane 6 acks → `busy`, `done`, `mem_re`, `mem_we`, and `ld_data` read 0 immediately; a new `start` after reset performs a clean 16-lane load.
- **Stride (`VMU_STRIDE_EN`):** `addr` = 0x0010, `stride` = 4 → lane addresses 0x0010, 0x0014, …, 0x004C; `stride` = 0 → all 16 reads hit 0x0010.
